// File: rtl/led_sched_pkg.sv
// rtl/led_sched_pkg.sv - state encoding, GRB channel layout and defaults for the LED refresh scheduler
// SCALE state and pixel scaling exist only with LED_REFRESH_SCHEDULER_BRIGHTNESS_EN defined.
package led_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_READ    = 3'd1,
    ST_RDWAIT  = 3'd2,
    ST_PRESENT = 3'd3,
    ST_DRAIN   = 3'd4,
    ST_LATCH   = 3'd5
`ifdef LED_REFRESH_SCHEDULER_BRIGHTNESS_EN
    , ST_SCALE = 3'd6
`endif
  } sched_state_e;

  localparam int CH_W     = 8;
  localparam int CH_G_LSB = 16;
  localparam int CH_R_LSB = 8;
  localparam int CH_B_LSB = 0;

  localparam int DEFAULT_LATCH_CYCLES = 2000;

  function automatic logic [CH_W-1:0] scale_chan(input logic [CH_W-1:0] c, input logic [7:0] b);
    logic [15:0] prod;
    prod = {8'd0, c} * {8'd0, b};
    return prod[15:8];
  endfunction

  function automatic logic [23:0] scale_pixel(input logic [23:0] p, input logic [7:0] b);
    return {scale_chan(p[CH_G_LSB +: CH_W], b),
            scale_chan(p[CH_R_LSB +: CH_W], b),
            scale_chan(p[CH_B_LSB +: CH_W], b)};
  endfunction

endpackage

// File: rtl/led_port_arbiter.sv
// rtl/led_port_arbiter.sv - framebuffer port grant between CPU writes and refresh reads
module led_port_arbiter
  import led_sched_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cpu_req,
  input  logic rd_req,
  output logic cpu_grant,
  output logic rd_grant
);

  localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  logic [CW-1:0] starve_cnt_q, starve_cnt_d;
  logic          starved;

  // CPU has priority until the refresh read has lost STARVE_MAX times in a row.
  always_comb begin
    starved      = rd_req && (starve_cnt_q == CW'(STARVE_MAX));
    cpu_grant    = cpu_req && !starved;
    rd_grant     = rd_req && !cpu_grant;
    starve_cnt_d = starve_cnt_q;
    if (rd_grant)
      starve_cnt_d = '0;
    else if (cpu_grant && rd_req && (starve_cnt_q != CW'(STARVE_MAX)))
      starve_cnt_d = starve_cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) starve_cnt_q <= '0;
    else        starve_cnt_q <= starve_cnt_d;
  end

endmodule

// File: rtl/led_refresh_scheduler.sv
// rtl/led_refresh_scheduler.sv - framebuffer-to-serializer refresh sequencer with latch gap
// LED_REFRESH_SCHEDULER_BRIGHTNESS_EN adds cfg_brightness and a per-pixel SCALE stage.
module led_refresh_scheduler
  import led_sched_pkg::*;
#(
  parameter int ADDR_W       = 6,
  parameter int DATA_W       = 24,
  parameter int LATCH_CYCLES = DEFAULT_LATCH_CYCLES,
  parameter int STARVE_MAX   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_enable,
  input  logic              cfg_auto,
  input  logic [ADDR_W:0]   cfg_led_count,
`ifdef LED_REFRESH_SCHEDULER_BRIGHTNESS_EN
  input  logic [7:0]        cfg_brightness,
`endif
  input  logic              start,
  output logic              busy,
  output logic              frame_done,
  input  logic              cpu_wr_req,
  input  logic [ADDR_W-1:0] cpu_wr_addr,
  input  logic [DATA_W-1:0] cpu_wr_data,
  output logic              cpu_wr_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              pix_valid,
  output logic [DATA_W-1:0] pix_data,
  input  logic              pix_ready,
  input  logic              ser_busy
);

  localparam int CNT_W    = ADDR_W + 1;
  localparam int MAX_LEDS = 1 << ADDR_W;
  localparam int LCW      = $clog2(LATCH_CYCLES + 1);
`ifdef LED_REFRESH_SCHEDULER_BRIGHTNESS_EN
  localparam sched_state_e POST_RD = ST_SCALE;
`else
  localparam sched_state_e POST_RD = ST_PRESENT;
`endif

  sched_state_e      state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_max_q, cnt_max_d;
  logic [DATA_W-1:0] pix_q, pix_d;
  logic [LCW-1:0]    latch_cnt_q, latch_cnt_d;
  logic              aborted_q, aborted_d;
`ifdef LED_REFRESH_SCHEDULER_BRIGHTNESS_EN
  logic [7:0]        bright_q, bright_d;
`endif

  logic             rd_req, rd_grant, cpu_grant;
  logic             start_ok, restart_ok, latch_end, is_last, handshake, in_fetch;
  logic [CNT_W-1:0] led_count_sat;

  led_port_arbiter #(.STARVE_MAX(STARVE_MAX)) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu_req   (cpu_wr_req),
    .rd_req    (rd_req),
    .cpu_grant (cpu_grant),
    .rd_grant  (rd_grant)
  );

  always_comb begin
    rd_req        = (state_q == ST_READ) && cfg_enable;
    start_ok      = start && cfg_enable && (cfg_led_count != '0);
    restart_ok    = cfg_auto && cfg_enable && (cfg_led_count != '0);
    latch_end     = (state_q == ST_LATCH) && (latch_cnt_q == LCW'(LATCH_CYCLES - 1));
    is_last       = ({1'b0, idx_q} == (cnt_max_q - CNT_W'(1)));
    handshake     = (state_q == ST_PRESENT) && pix_ready;
    led_count_sat = (cfg_led_count > CNT_W'(MAX_LEDS)) ? CNT_W'(MAX_LEDS) : cfg_led_count;
`ifdef LED_REFRESH_SCHEDULER_BRIGHTNESS_EN
    in_fetch      = (state_q == ST_READ) || (state_q == ST_RDWAIT) || (state_q == ST_SCALE);
`else
    in_fetch      = (state_q == ST_READ) || (state_q == ST_RDWAIT);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (start_ok) state_d = ST_READ;
      ST_READ:    if (!cfg_enable) state_d = ST_DRAIN;
                  else if (rd_grant) state_d = ST_RDWAIT;
      ST_RDWAIT:  state_d = cfg_enable ? POST_RD : ST_DRAIN;
`ifdef LED_REFRESH_SCHEDULER_BRIGHTNESS_EN
      ST_SCALE:   state_d = cfg_enable ? ST_PRESENT : ST_DRAIN;
`endif
      ST_PRESENT: if (pix_ready) state_d = (is_last || !cfg_enable) ? ST_DRAIN : ST_READ;
      ST_DRAIN:   if (!ser_busy) state_d = ST_LATCH;
      ST_LATCH:   if (latch_end) state_d = restart_ok ? ST_READ : ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    idx_d       = idx_q;
    cnt_max_d   = cnt_max_q;
    pix_d       = pix_q;
    latch_cnt_d = latch_cnt_q;
    aborted_d   = aborted_q;
`ifdef LED_REFRESH_SCHEDULER_BRIGHTNESS_EN
    bright_d    = bright_q;
`endif
    if (((state_q == ST_IDLE) && start_ok) || (latch_end && restart_ok)) begin
      idx_d     = '0;
      cnt_max_d = led_count_sat;
      aborted_d = 1'b0;
`ifdef LED_REFRESH_SCHEDULER_BRIGHTNESS_EN
      bright_d  = cfg_brightness;
`endif
    end
    if (state_q == ST_RDWAIT) pix_d = mem_rdata;
`ifdef LED_REFRESH_SCHEDULER_BRIGHTNESS_EN
    if (state_q == ST_SCALE) pix_d = scale_pixel(pix_q, bright_q);
`endif
    if (handshake && !is_last && cfg_enable) idx_d = idx_q + ADDR_W'(1);
    // A frame cut short before its last pixel is handed over is aborted.
    if ((in_fetch && !cfg_enable) || (handshake && !cfg_enable && !is_last)) aborted_d = 1'b1;
    if (state_q == ST_DRAIN) latch_cnt_d = '0;
    else if (state_q == ST_LATCH) latch_cnt_d = latch_cnt_q + LCW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q       <= '0;
      cnt_max_q   <= '0;
      pix_q       <= '0;
      latch_cnt_q <= '0;
      aborted_q   <= 1'b0;
`ifdef LED_REFRESH_SCHEDULER_BRIGHTNESS_EN
      bright_q    <= '0;
`endif
    end else begin
      idx_q       <= idx_d;
      cnt_max_q   <= cnt_max_d;
      pix_q       <= pix_d;
      latch_cnt_q <= latch_cnt_d;
      aborted_q   <= aborted_d;
`ifdef LED_REFRESH_SCHEDULER_BRIGHTNESS_EN
      bright_q    <= bright_d;
`endif
    end
  end

  always_comb begin
    busy       = (state_q != ST_IDLE);
    pix_valid  = (state_q == ST_PRESENT);
    pix_data   = pix_q;
    frame_done = latch_end && !aborted_q;
    cpu_wr_ack = cpu_grant;
    mem_en     = cpu_grant || rd_grant;
    mem_we     = cpu_grant;
    mem_addr   = cpu_grant ? cpu_wr_addr : idx_q;
    mem_wdata  = cpu_grant ? cpu_wr_data : '0;
  end

endmodule

// File: doc/led_refresh_scheduler.md
Name: led_refresh_scheduler

Overview:
Sequences refresh of a string-LED chain from a single-port pixel framebuffer. It reads pixels in address order and hands each one to the string-LED serializer over a valid/ready handshake. After the last pixel it enforces the latch/reset gap. It also arbitrates the one framebuffer port between CPU pixel writes and its own refresh reads; the CPU path is normally fed from the Wishbone/GPIO pixel_write path.

Parameters:
ADDR_W, 6, framebuffer address width; maximum chain length is 2**ADDR_W.
DATA_W, 24, pixel width in GRB order, 8 bits per channel.
LATCH_CYCLES, 2000, clocks of idle line after the last pixel (50 us at 40 MHz).
STARVE_MAX, 4, consecutive CPU grants allowed before a pending refresh read wins.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cfg_enable  in  1  scheduler enable
cfg_auto  in  1  restart the frame automatically after the latch gap
cfg_led_count  in  ADDR_W+1  number of LEDs, 1..2**ADDR_W
start  in  1  single-cycle pulse that starts one frame
busy  out  1  high from frame start until end of latch gap
frame_done  out  1  one-cycle pulse at the end of the latch gap of a completed frame
cpu_wr_req  in  1  CPU pixel write request, held until ack
cpu_wr_addr  in  ADDR_W  CPU write address
cpu_wr_data  in  DATA_W  CPU write data
cpu_wr_ack  out  1  one-cycle pulse in the cycle the write is issued to memory
mem_en  out  1  framebuffer port enable
mem_we  out  1  framebuffer write enable
mem_addr  out  ADDR_W  framebuffer address
mem_wdata  out  DATA_W  framebuffer write data
mem_rdata  in  DATA_W  read data, valid 1 clock after a read
pix_valid  out  1  pixel available to the serializer
pix_data  out  DATA_W  pixel value
pix_ready  in  1  serializer accepts the pixel
ser_busy  in  1  serializer still shifting bits

Behaviour:
- Reset (async, rst_n low): FSM goes to IDLE. All outputs are 0. Counters are cleared. Reset takes effect mid-frame with no drain.
- FSM states: IDLE, READ, RDWAIT, PRESENT, DRAIN, LATCH.
- IDLE -> READ: on start=1 while cfg_enable=1 and cfg_led_count!=0.
  - cfg_led_count is latched into cnt_max at this point.
  - The pixel index is set to 0 and busy is set to 1.
  - A start pulse is ignored when the scheduler is not in IDLE, when cfg_enable=0, or when cfg_led_count=0.
  - cfg_led_count values above 2**ADDR_W saturate to 2**ADDR_W.
- READ: requests a refresh read.
  - When granted, drive mem_en=1, mem_we=0, mem_addr=index, then go to RDWAIT.
  - While not granted, stay in READ.
- RDWAIT: capture mem_rdata into the pixel register, go to PRESENT.
- PRESENT: pix_valid=1 and pix_data is held stable until pix_ready.
  - On the handshake: if index==cnt_max-1, go to DRAIN; otherwise increment index and go to READ.
  - Minimum cost is 3 clocks per pixel.
- DRAIN: wait for ser_busy=0, then clear the latch counter and go to LATCH.
- LATCH: count LATCH_CYCLES clocks.
  - At the end, pulse frame_done for 1 clock.
  - If cfg_auto=1 and cfg_enable=1, reload index=0, relatch cfg_led_count and go to READ.
  - Otherwise go to IDLE and busy=0 in the following cycle.
- Abort: if cfg_enable goes to 0 in READ or RDWAIT, go to DRAIN. In PRESENT the current handshake completes first, then DRAIN. An aborted frame still waits the latch gap but does not pulse frame_done.
- Arbitration, evaluated each cycle:
  - A CPU write wins the memory port unless the FSM is in READ and starve_cnt==STARVE_MAX.
  - Winning write: mem_en=1, mem_we=1, address and data passed through, cpu_wr_ack=1 in the same cycle. starve_cnt increments, saturating, only when READ is also pending.
  - A refresh read grant clears starve_cnt.
  - CPU writes are accepted in every state, including IDLE and LATCH.
- Hazard: a write to an address already read this frame takes effect in the next frame. No bypass.

Optional Feature:
Macro: LED_REFRESH_SCHEDULER_BRIGHTNESS_EN.
- Defined:
  - Adds input cfg_brightness[7:0].
  - Each 8-bit channel becomes (chan*cfg_brightness)>>8, truncated, computed in one extra register stage (RDWAIT -> SCALE -> PRESENT), so each pixel costs one more clock.
  - cfg_brightness is sampled at frame start.
- Undefined: no port, no SCALE state, pixels pass through unchanged.

Decomposition:
- Package led_sched_pkg holds the FSM state enum, the GRB channel slice constants and the default LATCH_CYCLES.
- One natural sub-module, led_port_arbiter: the CPU/refresh grant logic with the starvation counter, combinational grant plus a registered counter.

Test Plan:
1. cfg_led_count=3, buffer holding 0x010203/0x040506/0x070809, pix_ready tied 1, start pulse -> pixels presented in that order, 3 clocks apart; after ser_busy falls, frame_done is high exactly LATCH_CYCLES clocks later; busy then drops.
2. cpu_wr_req held continuously during a frame, STARVE_MAX=4 -> refresh read granted after every 4 acks; the frame completes and the ack count matches the number of writes issued.
3. pix_ready low for 10 clocks in PRESENT -> pix_valid and pix_data stay stable, index does not advance, and no extra mem reads occur.
4. cfg_auto=1, two consecutive frames -> frame_done pulses twice with busy never dropping; a CPU write made during LATCH appears in the second frame.
5. cfg_enable deasserted while the 2nd of 5 pixels is in READ -> DRAIN and LATCH run, no frame_done, IDLE; a start with cfg_led_count=0 is ignored (busy stays 0).
6. rst_n pulsed low mid-PRESENT -> all outputs 0 asynchronously; a fresh start afterwards restarts from address 0.
